rf_cmd_sequencer: RTL

Command-driven initiator for the 4-entry, 9-bit register file used by the en/de-cryption datapath. Accepts one operation at a time over a valid/ready command port and drives the register file's write port and both read ports. Executes LOAD/XOR/ADD/READ operations and returns results over a valid/ready response port. Sits between the cipher control logic and the register file.

---
 rtl/rf_seq_pkg.sv | 23 ++
 rtl/rf_seq_alu.sv | 35 +++
 rtl/rf_cmd_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file command sequencer: op codes,
// FSM state encodings and default widths.
package rf_seq_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_ADDR_W = 2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_EXEC = S_EXEC;
  localparam logic [1:0] ST_RESP = S_RESP;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational result mux for LOAD/XOR/ADD/READ; produces both response words.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] res0,
  output logic [DATA_W-1:0] res1
);

  // Carry out of the top bit is intentionally dropped (mod 2^DATA_W).
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    res0 = '0;
    res1 = '0;
    case (op)
      OP_LOAD: res0 = imm;
      OP_XOR:  res0 = rd0 ^ rd1;
      OP_ADD:  res0 = add_wrap(rd0, rd1);
      default: begin
        res0 = rd0;
        res1 = rd1;
      end
    endcase
  end

endmodule

// File: rtl/rf_cmd_sequencer.sv
// One-at-a-time command sequencer driving a 4-entry register file:
// IDLE accepts, EXEC reads/writes for one cycle, RESP holds the result.
module rf_cmd_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data0,
  output logic [DATA_W-1:0] rsp_data1,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd0_addr,
  output logic [ADDR_W-1:0] rf_rd1_addr,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data
);

  logic [1:0]        state_q;
  logic [1:0]        op_p0;
  logic [ADDR_W-1:0] dst_p0;
  logic [ADDR_W-1:0] src0_p0;
  logic [ADDR_W-1:0] src1_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] rsp0_p1;
  logic [DATA_W-1:0] rsp1_p1;
  logic [DATA_W-1:0] alu_res0;
  logic [DATA_W-1:0] alu_res1;
  logic              exec;

  rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (op_p0),
    .imm  (imm_p0),
    .rd0  (rf_rd0_data),
    .rd1  (rf_rd1_data),
    .res0 (alu_res0),
    .res1 (alu_res1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_p0   <= '0;
      dst_p0  <= '0;
      src0_p0 <= '0;
      src1_p0 <= '0;
      imm_p0  <= '0;
      rsp0_p1 <= '0;
      rsp1_p1 <= '0;
    end else begin
      case (state_q)
        // p0: command capture
        ST_IDLE: begin
          if (cmd_valid) begin
            op_p0   <= cmd_op;
            dst_p0  <= cmd_dst;
            src0_p0 <= cmd_src0;
            src1_p0 <= cmd_src1;
            imm_p0  <= cmd_imm;
            state_q <= ST_EXEC;
          end
        end
        // p1: register-file access and response capture
        ST_EXEC: begin
          rsp0_p1 <= alu_res0;
          rsp1_p1 <= alu_res1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write strobe decodes from state, so reset removes it without waiting for a clock.
  assign exec        = (state_q == ST_EXEC);
  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data0   = rsp0_p1;
  assign rsp_data1   = rsp1_p1;
  assign rf_wr_en    = exec && (op_p0 != OP_READ);
  assign rf_wr_addr  = dst_p0;
  assign rf_wr_data  = rf_wr_en ? alu_res0 : '0;
  assign rf_rd0_addr = src0_p0;
  assign rf_rd1_addr = src1_p0;

endmodule
